adc_capture_buffer: RTL and testbench
=====================================

# adc_capture_buffer

Triggered capture buffer that sits directly downstream of the AD9467 interface and consumes its 16-bit reassembled samples. After arming, it keeps a rolling pre-trigger history in a ring buffer and detects a rising-edge level crossing. It then collects the post-trigger samples and streams the whole window out over a valid/ready port to the readout/SPI-side logic.

## Interface
Parameters:
- DATA_W, 16, sample width; matches the interface's 16-bit doubled sample.
- DEPTH, 256, total capture window in samples; power of two, ≥ 8.
- PRE_TRIG, 64, samples retained before the trigger sample; 1 ≤ PRE_TRIG < DEPTH.

Ports:
- adc_clk_in_p  in  1  sole clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- sample_in  in  DATA_W  sample from the AD9467 interface.
- sample_valid  in  1  sample_in valid this cycle; no backpressure upstream.
- arm  in  1  start a capture; honoured only in IDLE.
- trig_level  in  DATA_W  unsigned trigger threshold; sampled continuously.
- rd_ready  in  1  downstream accepts rd_data this cycle.
- rd_data  out  DATA_W  captured sample.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  marks the final (DEPTH-th) word of a window.
- armed  out  1  high in FILL and WAIT_TRIG.
- triggered  out  1  high in POST and READ.
- done  out  1  one-cycle pulse after the last word is accepted.
- sw_trig  in  1  forced trigger; present only with CAPTURE_SW_TRIG_EN.

## Operation
- State machine: IDLE → FILL → WAIT_TRIG → POST → READ → IDLE.
- IDLE: samples are discarded. When arm=1: clear the fill counter, load prev_sample with all-ones, go to FILL.
- FILL: each valid sample is written at wr_ptr, and wr_ptr increments mod DEPTH. After PRE_TRIG samples, go to WAIT_TRIG. Triggers are ignored in FILL.
- WAIT_TRIG: valid samples keep writing and wrapping.
  - Trigger condition: sample_valid && prev_sample < trig_level && sample_in ≥ trig_level, using an unsigned compare.
  - On trigger, the trigger sample is written normally and start_ptr = (trigger address − PRE_TRIG) mod DEPTH.
  - Then go to POST.
- prev_sample updates on every valid sample in FILL, WAIT_TRIG and POST.
- POST: the trigger sample counts as the first of DEPTH−PRE_TRIG post samples. When the count completes, go to READ.
- READ:
  - Reads DEPTH words starting at start_ptr, incrementing mod DEPTH. Incoming samples are discarded.
  - A word transfers when rd_valid && rd_ready.
  - rd_last is asserted with the DEPTH-th word. After that word is accepted: pulse done and return to IDLE.
- arm outside IDLE is ignored.
- Reset at any point, including mid-POST or mid-READ, returns to IDLE. Buffer contents are not cleared and are never exposed without a new capture.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_last=0, armed=0, triggered=0, done=0. State is IDLE and all pointers and counters are 0.
- Arm: arm high at edge N → armed=1 after edge N+1's registered update (visible the cycle after N).
- Trigger: trigger sample at edge T → triggered=1 from edge T+1.
- Read latency: memory is synchronous-read with a registered output. The first rd_valid goes high 2 cycles after entering READ.
- Read throughput: one word per cycle while rd_ready stays high.
- Backpressure: while rd_valid && !rd_ready, rd_data and rd_last hold stable. No word is dropped or duplicated.
- rd_valid falls the cycle after the last word is accepted; done=1 in that same cycle.
- Simultaneous arm and sample_valid in IDLE: the sample is discarded, and FILL starts with the next valid sample.

## Configuration
- CAPTURE_SW_TRIG_EN defined:
  - Adds the sw_trig input. sw_trig=1 in WAIT_TRIG triggers on that cycle's valid sample, regardless of level.
  - If no sample is valid that cycle, sw_trig is latched until the next valid sample.
  - sw_trig is ignored in other states.
- CAPTURE_SW_TRIG_EN undefined: the port is absent and only the level trigger exists.

## Test plan
Unless noted, DEPTH=16, PRE_TRIG=4, and input is a ramp 0,1,2,… with sample_valid=1 every cycle, starting right after arm.
- Basic: trig_level=20 → triggered after sample 20; readout is 16..31 in order, rd_last on 31, done pulses once.
- Wrap: trig_level=100 → readout 96..111; the start pointer wraps correctly.
- Fill suppression: trig_level=2 → no trigger during FILL; stays in WAIT_TRIG, done never asserts.
- Backpressure: basic case with rd_ready toggling pseudo-randomly → exactly 16 words 16..31, data stable while stalled.
- Reset mid-POST: drive RESET=0 after sample 24 → all outputs 0 and state IDLE; re-arm with trig_level=40 → readout 36..51.
- CAPTURE_SW_TRIG_EN: constant input 0x1234 with sw_trig pulsed in WAIT_TRIG → 16 words of 0x1234, done pulses.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// Triggered capture buffer: pre-trigger ring history, rising-edge level trigger,
// post-trigger fill and valid/ready readout. Optional CAPTURE_SW_TRIG_EN adds sw_trig.
module adc_capture_buffer #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic              adc_clk_in_p,
    input  logic              RESET,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              armed,
    output logic              triggered,
    output logic              done
`ifdef CAPTURE_SW_TRIG_EN
    ,
    input  logic              sw_trig
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_TRIG - 1);
    localparam logic [CW-1:0] POST_LAST  = CW'(DEPTH - PRE_TRIG - 1);
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_LAST = CW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFF    = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FILL = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_POST = 3'd3;
    localparam logic [2:0] ST_READ = 3'd4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;

    logic [2:0]        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     start_ptr_q, start_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              s1_valid_q, s1_last_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_last_q, armed_q, triggered_q, done_q;

    logic wr_en_s, level_hit_s, sw_hit_s, trig_s, pipe_adv_s, issue_s, accept_last_s;

    assign wr_en_s       = sample_valid && ((state_q == ST_FILL) || (state_q == ST_WAIT) || (state_q == ST_POST));
    assign level_hit_s   = (prev_q < trig_level) && (sample_in >= trig_level);
    assign trig_s        = sample_valid && (state_q == ST_WAIT) && (level_hit_s || sw_hit_s);
    assign pipe_adv_s    = !rd_valid_q || rd_ready;
    assign issue_s       = (state_q == ST_READ) && pipe_adv_s && (rd_cnt_q != DEPTH_CNT);
    assign accept_last_s = rd_valid_q && rd_ready && rd_last_q;

`ifdef CAPTURE_SW_TRIG_EN
    logic sw_pend_q;
    assign sw_hit_s = sw_trig || sw_pend_q;

    // Hold a software trigger that arrives on a cycle without a valid sample.
    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            sw_pend_q <= 1'b0;
        end else if ((state_q == ST_WAIT) && sw_trig && !sample_valid) begin
            sw_pend_q <= 1'b1;
        end else if ((state_q != ST_WAIT) || sample_valid) begin
            sw_pend_q <= 1'b0;
        end
    end
`else
    assign sw_hit_s = 1'b0;
`endif

    // Capture sequencing: pointers, counters and state transitions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_ptr_d = start_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        wr_ptr_d    = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        prev_d      = wr_en_s ? sample_in : prev_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    cnt_d   = '0;
                    prev_d  = '1;
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (sample_valid && (cnt_q == PRE_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else if (sample_valid) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT: begin
                if (trig_s) begin
                    start_ptr_d = wr_ptr_q - PRE_OFF;
                    cnt_d       = CNT_ONE;
                    if (DEPTH - PRE_TRIG == 1) begin
                        rd_ptr_d = wr_ptr_q - PRE_OFF;
                        rd_cnt_d = '0;
                        state_d  = ST_READ;
                    end else begin
                        state_d = ST_POST;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_POST: begin
                if (sample_valid && (cnt_q == POST_LAST)) begin
                    rd_ptr_d = start_ptr_q;
                    rd_cnt_d = '0;
                    state_d  = ST_READ;
                end else if (sample_valid) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
                if (accept_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sample memory with synchronous, registered read port.
    always_ff @(posedge adc_clk_in_p) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= sample_in;
        end
        if (issue_s) begin
            mem_rd_q <= mem[rd_ptr_q];
        end
    end

    // Control state plus two-stage read pipeline; both stages stall together under backpressure.
    always_ff @(posedge adc_clk_in_p or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_cnt_q    <= '0;
            prev_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            prev_q      <= prev_d;
            armed_q     <= (state_d == ST_FILL) || (state_d == ST_WAIT);
            triggered_q <= (state_d == ST_POST) || (state_d == ST_READ);
            done_q      <= accept_last_s;
            if (state_q != ST_READ) begin
                s1_valid_q <= 1'b0;
                s1_last_q  <= 1'b0;
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
                rd_last_q  <= 1'b0;
            end else if (pipe_adv_s) begin
                s1_valid_q <= issue_s;
                s1_last_q  <= issue_s && (rd_cnt_q == DEPTH_LAST);
                rd_data_q  <= s1_valid_q ? mem_rd_q : '0;
                rd_valid_q <= s1_valid_q;
                rd_last_q  <= s1_last_q;
            end else begin
                s1_valid_q <= s1_valid_q;
                rd_valid_q <= rd_valid_q;
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign armed     = armed_q;
    assign triggered = triggered_q;
    assign done      = done_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized self-checking bench for adc_capture_buffer; the reference model locates
// the trigger in the driven sample list and slices the expected window out of it.
module tb_adc_capture_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int POST  = DEPTH - PRE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          arm = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, armed, triggered, done;
`ifdef CAPTURE_SW_TRIG_EN
    logic          sw_trig = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] stim [$];

    always #5 clk = ~clk;

    adc_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
        .adc_clk_in_p (clk),
        .RESET        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .arm          (arm),
        .trig_level   (trig_level),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_last      (rd_last),
        .armed        (armed),
        .triggered    (triggered),
        .done         (done)
`ifdef CAPTURE_SW_TRIG_EN
        ,
        .sw_trig      (sw_trig)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Index of the trigger sample in stim, or -1: first sample after the PRE fill
    // samples that crosses the level upward, or that follows a software trigger.
    function automatic int find_trig(input int lim, input logic [DW-1:0] lvl, input int sw_idx);
        for (int k = PRE; k < lim; k++) begin
            if (sw_idx >= 0 && k >= sw_idx) return k;
            if (stim[k-1] < lvl && stim[k] >= lvl) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {11'd0, rd_data, rd_valid, rd_last, armed, triggered, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: ramp every cycle, 1: random data/valid with stray arm, 2: constant 0x1234
    task automatic run_capture(input int mode, input logic [DW-1:0] lvl, input int len,
                               input int abort_at, input int rdy_rand, input int sw_idx);
        int k, n_drive, c, idx, cyc;
        logic v, exp_trig, sw_done;
        stim.delete();
        for (int i = 0; i < len; i++) begin
            if (mode == 0)      stim.push_back(DW'(i));
            else if (mode == 1) stim.push_back(DW'($urandom_range(0, 255)));
            else                stim.push_back(16'h1234);
        end
        k       = find_trig(len - POST, lvl, sw_idx);
        n_drive = (k >= 0) ? (k + POST) : (len - POST);
        if (abort_at >= 0) n_drive = abort_at;

        trig_level   = lvl;
        arm          = 1'b1;
        sample_valid = 1'b1;
        sample_in    = 16'hBEEF;
        @(negedge clk);
        arm = 1'b0;
        check_eq("armed_after_arm", armed, 32'd1);
        check_eq("trig_after_arm", triggered, 32'd0);

        c = 0;
        sw_done = 1'b0;
        while (c < n_drive) begin
            v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
`ifdef CAPTURE_SW_TRIG_EN
            sw_trig = 1'b0;
            if (sw_idx >= 0 && c == sw_idx && !sw_done) begin
                sw_trig = 1'b1;
                v       = 1'b0;
                sw_done = 1'b1;
            end
`endif
            if (mode == 1) arm = ($urandom_range(0, 1) == 1);
            sample_valid = v;
            sample_in    = v ? stim[c] : DW'($urandom);
            @(negedge clk);
            if (v) c++;
            exp_trig = (k >= 0) && (c > k);
            check_eq("armed", armed, !exp_trig);
            check_eq("triggered", triggered, exp_trig);
            check_eq("no_early_valid", rd_valid, 32'd0);
            check_eq("no_early_done", done, 32'd0);
        end
        sample_valid = 1'b0;
        arm          = 1'b0;
`ifdef CAPTURE_SW_TRIG_EN
        sw_trig = 1'b0;
`endif
        if (abort_at >= 0) begin
            do_reset();
            return;
        end
        if (k < 0) begin
            repeat (40) @(negedge clk);
            check_eq("no_trig_done", done, 32'd0);
            check_eq("no_trig_armed", armed, 32'd1);
            check_eq("no_trig_triggered", triggered, 32'd0);
            do_reset();
            return;
        end

        rd_ready = 1'b0;
        @(negedge clk);
        check_eq("read_lat1", rd_valid, 32'd0);
        @(negedge clk);
        check_eq("read_lat2", rd_valid, 32'd1);

        idx = 0;
        cyc = 0;
        while (idx < DEPTH && cyc < 400) begin
            rd_ready = (rdy_rand != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            check_eq("done_during_read", done, 32'd0);
            if (rd_valid) begin
                check_eq("rd_data", rd_data, stim[k - PRE + idx]);
                check_eq("rd_last", rd_last, (idx == DEPTH - 1));
                if (rd_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        rd_ready = 1'b0;
        check_eq("word_count", idx, DEPTH);
        check_eq("done_pulse", done, 32'd1);
        check_eq("valid_fall", rd_valid, 32'd0);
        check_eq("idle_flags", {armed, triggered}, 32'd0);
        @(negedge clk);
        check_eq("done_single", done, 32'd0);
        if (idx != DEPTH) do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_outputs", {11'd0, rd_data, rd_valid, rd_last, armed, triggered, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_capture(0, 16'd20,  60,  -1, 0, -1);   // basic: 16..31
        run_capture(0, 16'd100, 140, -1, 0, -1);   // wrap: 96..111
        run_capture(0, 16'd2,   60,  -1, 0, -1);   // no trigger inside fill
        run_capture(0, 16'd20,  60,  -1, 1, -1);   // backpressure
        run_capture(0, 16'd20,  60,  25, 0, -1);   // reset mid-post after sample 24
        run_capture(0, 16'd40,  80,  -1, 0, -1);   // re-arm: 36..51
        for (int t = 0; t < 8; t++) begin
            run_capture(1, DW'($urandom_range(40, 220)), 200, -1, 1, -1);
        end
`ifdef CAPTURE_SW_TRIG_EN
        run_capture(2, 16'hFFFF, 60, -1, 1, 6);
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
